// File: rtl/mod_updown_counter_pkg.sv
// Shared definitions for the modulo up/down counter.
//   DIR_UP / DIR_DN  : encodings of the 'up' direction input
//   terminal_value() : value at which a count event wraps or saturates,
//                      given the modulus and the direction
package mod_updown_counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // 64-bit so that MODULUS = 2**32 is representable.
    function automatic longint unsigned terminal_value(input longint unsigned modulus,
                                                       input logic            dir);
        return (dir == DIR_UP) ? modulus - 64'd1 : 64'd0;
    endfunction

endpackage

// File: rtl/count_next_logic.sv
// Combinational next-state arithmetic for mod_updown_counter.
//   a_i         : current counter value
//   up_i        : direction (1 = increment, 0 = decrement)
//   i_i         : parallel-load data
//   count_val_o : value the counter takes on a count event
//   at_term_o   : a_i equals the terminal value for the current direction
//   load_val_o  : value the counter takes on a load (clamped to MODULUS-1)
//   load_oor_o  : load data is out of range (i_i >= MODULUS)
module count_next_logic
    import mod_updown_counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter bit              SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             up_i,
    input  logic [WIDTH-1:0] i_i,
    output logic [WIDTH-1:0] count_val_o,
    output logic             at_term_o,
    output logic [WIDTH-1:0] load_val_o,
    output logic             load_oor_o
);

    localparam logic [WIDTH-1:0] TermUp = WIDTH'(terminal_value(MODULUS, DIR_UP));
    localparam logic [WIDTH-1:0] TermDn = WIDTH'(terminal_value(MODULUS, DIR_DN));
    localparam logic [WIDTH:0]   One    = (WIDTH + 1)'(1);

    logic [WIDTH-1:0] term;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   step;
    logic             unused_step_msb;

    always_comb begin
        term      = (up_i == DIR_UP) ? TermUp : TermDn;
        at_term_o = (a_i == term);

        // One guard bit so the +/-1 is never truncated mid-expression; away
        // from the terminal value the result always fits back into WIDTH bits.
        a_ext = {1'b0, a_i};
        step  = (up_i == DIR_UP) ? a_ext + One : a_ext - One;

        if (!at_term_o) begin
            count_val_o = step[WIDTH-1:0];
        end else if (SATURATE) begin
            count_val_o = a_i;
        end else begin
            // Wrap to the opposite end of the range.
            count_val_o = (up_i == DIR_UP) ? TermDn : TermUp;
        end

        load_oor_o = (64'(i_i) >= MODULUS);
        load_val_o = load_oor_o ? TermUp : i_i;
    end

    assign unused_step_msb = step[WIDTH];

endmodule

// File: rtl/mod_updown_counter.sv
// Loadable modulo-N up/down counter with wrap or saturate behaviour.
//   clk      : clock, all state changes on the rising edge
//   reset    : synchronous active-high reset (a, ovf, load_err -> 0)
//   load     : parallel load of i (clamped to MODULUS-1, flags load_err)
//   count    : count enable
//   up       : direction, 1 = increment, 0 = decrement
//   i        : parallel-load data
//   a        : registered counter value
//   c_out    : combinational terminal-count carry/borrow
//   ovf      : registered sticky wrap/saturate flag, cleared by load/reset
//   load_err : registered flag, last load was out of range
// Edge priority: reset > load > count > hold.
module mod_updown_counter
    import mod_updown_counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             count,
    input  logic             up,
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] a,
    output logic             c_out,
    output logic             ovf,
    output logic             load_err
);

    if (WIDTH < 2 || WIDTH > 32) begin : gen_bad_width
        $fatal(1, "mod_updown_counter: WIDTH must be in 2..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : gen_bad_modulus
        $fatal(1, "mod_updown_counter: MODULUS must be in 2..2**WIDTH");
    end

    logic [WIDTH-1:0] a_q, a_d;
    logic             ovf_q, ovf_d;
    logic             load_err_q, load_err_d;

    logic [WIDTH-1:0] count_val;
    logic             at_term;
    logic [WIDTH-1:0] load_val;
    logic             load_oor;

    count_next_logic #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .a_i         (a_q),
        .up_i        (up),
        .i_i         (i),
        .count_val_o (count_val),
        .at_term_o   (at_term),
        .load_val_o  (load_val),
        .load_oor_o  (load_oor)
    );

    // Load / count / hold; reset is applied in the register block.
    always_comb begin
        a_d        = a_q;
        ovf_d      = ovf_q;
        load_err_d = load_err_q;
        if (load) begin
            a_d        = load_val;
            load_err_d = load_oor;
            ovf_d      = 1'b0;
        end else if (count) begin
            a_d = count_val;
            if (at_term) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q        <= '0;
            ovf_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            a_q        <= a_d;
            ovf_q      <= ovf_d;
            load_err_q <= load_err_d;
        end
    end

    assign a        = a_q;
    assign ovf      = ovf_q;
    assign load_err = load_err_q;
    assign c_out    = count & ~load & ~reset & at_term;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: a wrapping and a saturating instance
// (WIDTH=4, MODULUS=10) share one stimulus stream.
module tb_mod_updown_counter;

    localparam int MOD = 10;

    logic       clk = 1'b0;
    logic       reset, load, count, up;
    logic [3:0] i;
    logic [3:0] a_w, a_s;
    logic       c_w, c_s, o_w, o_s, e_w, e_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b0)) dut_wrap (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .count    (count),
        .up       (up),
        .i        (i),
        .a        (a_w),
        .c_out    (c_w),
        .ovf      (o_w),
        .load_err (e_w)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b1)) dut_sat (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .count    (count),
        .up       (up),
        .i        (i),
        .a        (a_s),
        .c_out    (c_s),
        .ovf      (o_s),
        .load_err (e_s)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Behavioural model: index 0 = wrapping instance, 1 = saturating instance.
    int m_a[2];
    bit m_ovf[2];
    bit m_err[2];
    bit m_valid = 1'b0;

    task automatic model_step(input logic r, input logic l, input logic c, input logic u,
                              input int iv);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_a[k] = 0; m_ovf[k] = 0; m_err[k] = 0;
            end else if (l) begin
                m_a[k]   = (iv < MOD) ? iv : MOD - 1;
                m_err[k] = (iv >= MOD);
                m_ovf[k] = 0;
            end else if (c) begin
                if (u ? (m_a[k] == MOD - 1) : (m_a[k] == 0)) begin
                    m_ovf[k] = 1;
                    if (k == 0) m_a[k] = u ? 0 : MOD - 1;
                end else begin
                    m_a[k] = u ? (m_a[k] + 1) % MOD : (m_a[k] + MOD - 1) % MOD;
                end
            end
        end
        if (r) m_valid = 1'b1;
    endtask

    function automatic bit exp_cout(input int k);
        return count && !load && !reset && (m_a[k] == (up ? MOD - 1 : 0));
    endfunction

    // Every cycle once the state is defined.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_a_wrap",   a_w, m_a[0]);
            check("model_ovf_wrap", o_w, m_ovf[0]);
            check("model_err_wrap", e_w, m_err[0]);
            check("model_cout_wrap", c_w, exp_cout(0));
            check("model_a_sat",    a_s, m_a[1]);
            check("model_ovf_sat",  o_s, m_ovf[1]);
            check("model_err_sat",  e_s, m_err[1]);
            check("model_cout_sat", c_s, exp_cout(1));
        end
    end

    // Pre-edge samples captured by cyc().
    logic [3:0] pa_w, pa_s;
    logic       pc_w, pc_s, po_w;

    task automatic cyc(input logic r, input logic l, input logic c, input logic u,
                       input logic [3:0] iv);
        reset = r; load = l; count = c; up = u; i = iv;
        #2;
        pa_w = a_w; pa_s = a_s; pc_w = c_w; pc_s = c_s; po_w = o_w;
        @(posedge clk);
        model_step(r, l, c, u, int'(iv));
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; load = 1'b0; count = 1'b0; up = 1'b1; i = 4'd0;

        cyc(1, 0, 0, 1, 0);
        check("rst_a_w", a_w, 0); check("rst_ovf_w", o_w, 0); check("rst_err_w", e_w, 0);
        check("rst_a_s", a_s, 0);

        // 12 clocks of up-count from 0.
        for (int k = 0; k < 12; k++) begin
            cyc(0, 0, 1, 1, 0);
            check($sformatf("up12_a_w[%0d]", k), pa_w, (k < 10) ? k : k - 10);
            check($sformatf("up12_cout_w[%0d]", k), pc_w, (k == 9));
            check($sformatf("up12_ovf_w[%0d]", k), po_w, (k >= 10));
            check($sformatf("up12_a_s[%0d]", k), pa_s, (k < 9) ? k : 9);
            check($sformatf("up12_cout_s[%0d]", k), pc_s, (k >= 9));
        end
        check("up12_ovf_after", o_w, 1);

        // Load 8 then saturate at 9.
        cyc(0, 1, 0, 1, 8);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 1, 1, 0);
            check($sformatf("sat_a_s[%0d]", k), pa_s, (k == 0) ? 8 : 9);
            check($sformatf("sat_cout_s[%0d]", k), pc_s, (k >= 1));
            check($sformatf("sat_a_w[%0d]", k), pa_w, (k == 0) ? 8 : ((k == 1) ? 9 : k - 2));
        end
        check("sat_ovf_s", o_s, 1);

        // Out-of-range load clamps, then an in-range load clears the error.
        cyc(0, 1, 0, 1, 12);
        check("oor_a", a_w, 9); check("oor_err", e_w, 1); check("oor_ovf", o_w, 0);
        check("oor_a_s", a_s, 9);
        cyc(0, 1, 0, 1, 3);
        check("ld3_a", a_w, 3); check("ld3_err", e_w, 0);

        // Down-count from 1 across zero.
        cyc(0, 1, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, 0, 0);
            check($sformatf("dn_a_w[%0d]", k), a_w, (k == 0) ? 0 : ((k == 1) ? 9 : 8));
            check($sformatf("dn_cout_w[%0d]", k), pc_w, (k == 1));
            check($sformatf("dn_a_s[%0d]", k), a_s, 0);
        end
        check("dn_ovf_w", o_w, 1);

        // Load and count on the same edge: load wins, c_out masked.
        cyc(0, 1, 1, 0, 5);
        check("ldcnt_cout_s", pc_s, 0); check("ldcnt_cout_w", pc_w, 0);
        check("ldcnt_a_w", a_w, 5); check("ldcnt_a_s", a_s, 5);

        // Reset beats load and count; flags set beforehand.
        cyc(0, 1, 0, 1, 12);
        cyc(0, 0, 1, 1, 0);
        check("pre_rst_ovf_s", o_s, 1); check("pre_rst_err_s", e_s, 1);
        cyc(1, 1, 1, 1, 7);
        check("rstpri_cout_s", pc_s, 0);
        check("rstpri_a_w", a_w, 0); check("rstpri_ovf_w", o_w, 0);
        check("rstpri_err_w", e_w, 0);
        check("rstpri_a_s", a_s, 0); check("rstpri_ovf_s", o_s, 0);
        check("rstpri_err_s", e_s, 0);

        // Reset mid-count, first count after release advances from 0.
        for (int k = 0; k < 3; k++) cyc(0, 0, 1, 1, 0);
        check("mid_a_w", a_w, 3);
        cyc(1, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 0);
        check("after_rst_a_w", a_w, 1);

        // Hold with load=0, count=0 regardless of up and i.
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, k[0], 4'(k + 9));
        check("hold_a_w", a_w, 1); check("hold_a_s", a_s, 1);

        // Mixed directed pattern with direction changes between edges.
        for (int k = 0; k < 24; k++) begin
            cyc(0, (k == 7) || (k == 15), (k % 3) != 0, (k[0] ^ k[2]),
                (k == 7) ? 4'd15 : 4'd8);
        end

        cyc(0, 0, 0, 1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 Parameter MODULUS, default 2**WIDTH: count range 0..MODULUS-1; legal range 2..2**WIDTH.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at the terminal value, 1 = hold at the terminal value.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 load  input  1  parallel-load request.
REQ-007 count  input  1  count enable.
REQ-008 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-009 i  input  WIDTH  parallel-load data.
REQ-010 a  output  WIDTH  registered counter value.
REQ-011 c_out  output  1  combinational terminal-count carry/borrow.
REQ-012 ovf  output  1  registered sticky wrap/saturate flag.
REQ-013 load_err  output  1  registered flag: the last load was out of range.

Function
REQ-014 Priority per edge SHALL be reset > load > count > hold.
REQ-015 Load SHALL set a <= i when i < MODULUS, and clear load_err.
REQ-016 Load with i >= MODULUS SHALL set a <= MODULUS-1 and set load_err to 1.
REQ-017 Every load SHALL clear ovf.
REQ-018 Terminal value T SHALL be MODULUS-1 when up=1 and 0 when up=0.
REQ-019 Count with a != T SHALL set a <= a+1 (up) or a <= a-1 (down), evaluated in WIDTH+1 bits with no intermediate truncation.
REQ-020 Count with a == T and SATURATE=0 SHALL wrap: a <= 0 (up) or a <= MODULUS-1 (down), and set ovf.
REQ-021 Count with a == T and SATURATE=1 SHALL leave a unchanged and set ovf.
REQ-022 c_out SHALL equal count & ~load & ~reset & (a == T), asserting in the same cycle as the wrap or saturate edge.
REQ-023 ovf SHALL stay set until reset or load; count events never clear it.
REQ-024 load_err SHALL change only on load or reset.
REQ-025 A change of up between edges SHALL take effect on the next edge with no extra latency; count latency is one clock.
REQ-026 With load=0 and count=0, a, ovf and load_err SHALL hold.
REQ-027 With WIDTH=4, MODULUS=16, SATURATE=0 and up=1, behaviour SHALL match the legacy 4-bit load/count counter (with c_out additionally gated by ~load), except that reset is synchronous.

Reset
REQ-028 When reset=1 at an edge: a <= 0, ovf <= 0, load_err <= 0, regardless of load and count.
REQ-029 Reset asserted mid-count SHALL take effect at that edge; the first count after release SHALL advance from 0.
REQ-030 There SHALL be no asynchronous reset path; a is undefined until the first reset edge.

Structure
REQ-031 A shared package SHALL hold the direction constants (DIR_UP=1, DIR_DN=0) and a localparam function that computes the terminal value from MODULUS and direction.
REQ-032 Next-state arithmetic (next value, wrap/saturate decision, terminal detect) SHALL live in one combinational sub-module, count_next_logic; the top level holds only registers and the priority mux.
REQ-033 An elaboration-time check SHALL reject MODULUS < 2, MODULUS > 2**WIDTH, or WIDTH outside 2..32.

Verification
REQ-034 WIDTH=4, MODULUS=10, SATURATE=0: reset, then count=1 up=1 for 12 clocks -> a goes 0..9,0,1; c_out high only in the cycle a=9; ovf set from the wrap edge onward.
REQ-035 MODULUS=10, SATURATE=1: load i=8, then count up 4 clocks -> a goes 8,9,9,9; ovf=1; c_out high while a=9 and count=1.
REQ-036 Load i=12 with MODULUS=10 -> a=9, load_err=1, ovf=0; then load i=3 -> a=3, load_err=0.
REQ-037 Down count from a=1 for 3 clocks with SATURATE=0, MODULUS=10 -> a goes 0,9,8; c_out high in the cycle a=0; ovf=1.
REQ-038 load=1 and count=1 on the same edge with i=5 -> a=5 with no increment; c_out=0 that cycle.
REQ-039 reset=1 together with load=1, count=1 and i=7 -> a=0, ovf=0, load_err=0; c_out=0 during reset.
